instr_fetch_unit: RTL and testbench

Front end of the 8-bit single-cycle processor. It owns the program counter and drives the instruction memory address bus. After a fixed wait it samples the memory data bus and queues each {pc, instruction} pair in a small FIFO. Decode drains the FIFO through a valid/ready handshake, and a taken branch flushes all in-flight and queued fetches.

---
 rtl/instr_fetch_unit.sv | 154 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC/ABUS owner, wait-state sampler, {pc,instr} FIFO.
// Optional HALT-on-8'hFF behaviour is enabled by defining IFU_HALT_EN.
module instr_fetch_unit #(
  parameter int              ADDR_W      = 8,
  parameter int              DATA_W      = 8,
  parameter int              WAIT_CYCLES = 1,
  parameter int              FIFO_DEPTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00
) (
  input  logic              CLK,
  input  logic              RST,
  output logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DATABUS,
  output logic [DATA_W-1:0] INSTR,
  output logic [ADDR_W-1:0] INSTR_PC,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  output logic              HALTED
);

  localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_RST = CW'(WAIT_CYCLES);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_FULL  = 2'd1;
`ifdef IFU_HALT_EN
  localparam logic [1:0] S_HALT  = 2'd2;
`endif

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] abus_q, abus_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [PW-1:0]     rd_q, rd_d;
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW:0]       count_q, count_d;

  logic [ADDR_W-1:0] pc_mem  [FIFO_DEPTH];
  logic [DATA_W-1:0] ins_mem [FIFO_DEPTH];

  logic valid;
  logic pop;
  logic room;
  logic push;
  logic flush;

  assign valid = (count_q != '0);
  assign pop   = valid && INSTR_READY;
  assign room  = (count_q < DEPTH_C) || pop;
  assign flush = BR_TAKEN;

  always_comb begin
    state_d = state_q;
    abus_d  = abus_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    if (BR_TAKEN) begin
      state_d = S_FETCH;
      abus_d  = BR_TARGET;
      cnt_d   = CNT_RST;
    end else begin
      unique case (1'b1)
        (state_q == S_FETCH): begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else if (room) begin
            push   = 1'b1;
            abus_d = abus_q + 1'b1;
            cnt_d  = CNT_RST;
`ifdef IFU_HALT_EN
            // The HALT opcode itself is still delivered to decode.
            if (DATABUS == 8'hFF) begin
              state_d = S_HALT;
            end
`endif
          end else begin
            state_d = S_FULL;
          end
        end
        (state_q == S_FULL): begin
          // Re-read memory at the held address on the cycle after a pop.
          if (pop) begin
            state_d = S_FETCH;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    count_d = count_q;
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_FETCH;
      abus_q  <= RESET_PC;
      cnt_q   <= CNT_RST;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      abus_q  <= abus_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      pc_mem[wr_q]  <= abus_q;
      ins_mem[wr_q] <= DATABUS;
    end
  end

  assign ABUS        = abus_q;
  assign INSTR_VALID = valid;
  assign INSTR       = valid ? ins_mem[rd_q] : '0;
  assign INSTR_PC    = valid ? pc_mem[rd_q] : '0;

`ifdef IFU_HALT_EN
  assign HALTED = (state_q == S_HALT);
`else
  assign HALTED = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed phases push expected
// {pc,instr} pairs; a negedge monitor pops and compares on each handshake.
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic       br;
  logic [7:0] tgt;
  logic [7:0] abus;
  logic [7:0] databus;
  logic [7:0] instr;
  logic [7:0] ipc;
  logic       valid;
  logic       halted;
  logic       halt_mem;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] ins;
  } pair_t;

  pair_t exp_q[$];
  int    checks    = 0;
  int    passed    = 0;
  int    delivered = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] ram(input logic [7:0] a);
    if (halt_mem && a == 8'h03) return 8'hFF;
    return a ^ 8'h5A;
  endfunction

  assign databus = ram(abus);

  instr_fetch_unit dut (
    .CLK        (clk),
    .RST        (rst),
    .ABUS       (abus),
    .DATABUS    (databus),
    .INSTR      (instr),
    .INSTR_PC   (ipc),
    .INSTR_VALID(valid),
    .INSTR_READY(ready),
    .BR_TAKEN   (br),
    .BR_TARGET  (tgt),
    .HALTED     (halted)
  );

  always @(negedge clk) begin
    if (!rst && valid && ready) begin
      pair_t e;
      checks++;
      delivered++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pop: got pc=%0h instr=%0h, none expected",
                 ipc, instr);
      end else begin
        e = exp_q.pop_front();
        if (ipc === e.pc && instr === e.ins) passed++;
        else $display("FAIL pop: got pc=%0h instr=%0h, want pc=%0h instr=%0h",
                      ipc, instr, e.pc, e.ins);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, req);
  endtask

  task automatic expect_run(input logic [7:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] a;
      a = start + 8'(i);
      exp_q.push_back({a, ram(a)});
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_deliv(input int n);
    int goal;
    int b;
    goal = delivered + n;
    b = 0;
    while (delivered < goal && b < 200) begin
      step(1);
      b++;
    end
    chk("deliver_count", 8'(delivered >= goal), 8'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br  = 1'b0;
    step(2);
    exp_q.delete();
  endtask

  initial begin
    rst      = 1'b1;
    ready    = 1'b1;
    br       = 1'b0;
    tgt      = 8'h00;
    halt_mem = 1'b0;
    step(2);

    chk("rst_abus", abus, 8'h00);
    chk("rst_valid", 8'(valid), 8'd0);
    chk("rst_instr", instr, 8'h00);
    chk("rst_pc", ipc, 8'h00);
    chk("rst_halted", 8'(halted), 8'd0);

    // Streaming with decode always ready.
    exp_q.delete();
    expect_run(8'h00, 10);
    rst = 1'b0;
    step(1);
    chk("first_valid_lo", 8'(valid), 8'd0);
    step(1);
    chk("first_valid_hi", 8'(valid), 8'd1);
    chk("first_pc", ipc, 8'h00);
    chk("abus_after_push", abus, 8'h01);
    wait_deliv(6);

    // Back-pressure: FIFO fills, FULL holds the address.
    do_reset();
    ready = 1'b0;
    expect_run(8'h00, 10);
    rst = 1'b0;
    step(10);
    chk("full_abus", abus, 8'h02);
    chk("full_valid", 8'(valid), 8'd1);
    chk("full_head", ipc, 8'h00);
    ready = 1'b1;
    wait_deliv(4);

    // Redirect while FIFO full and retry pending; stale pcs never appear.
    do_reset();
    ready = 1'b0;
    rst = 1'b0;
    step(10);
    br  = 1'b1;
    tgt = 8'h40;
    step(1);
    br = 1'b0;
    exp_q.delete();
    chk("br_valid", 8'(valid), 8'd0);
    chk("br_abus", abus, 8'h40);
    expect_run(8'h40, 8);
    ready = 1'b1;
    wait_deliv(3);

    // Address wrap through 8'hFF.
    br  = 1'b1;
    tgt = 8'hFE;
    step(1);
    br = 1'b0;
    exp_q.delete();
    chk("wrap_abus", abus, 8'hFE);
    expect_run(8'hFE, 8);
    wait_deliv(4);

    // Reset beats a simultaneous branch.
    br  = 1'b1;
    rst = 1'b1;
    tgt = 8'h80;
    step(1);
    br = 1'b0;
    exp_q.delete();
    chk("rstbr_abus", abus, 8'h00);
    chk("rstbr_valid", 8'(valid), 8'd0);
    expect_run(8'h00, 6);
    rst = 1'b0;
    wait_deliv(2);

    // HALT opcode at address 3.
    halt_mem = 1'b1;
    do_reset();
`ifdef IFU_HALT_EN
    expect_run(8'h00, 4);
    rst = 1'b0;
    wait_deliv(4);
    step(6);
    chk("halt_flag", 8'(halted), 8'd1);
    chk("halt_abus", abus, 8'h04);
    chk("halt_drained", 8'(valid), 8'd0);
    br  = 1'b1;
    tgt = 8'h10;
    step(1);
    br = 1'b0;
    exp_q.delete();
    chk("resume_halted", 8'(halted), 8'd0);
    chk("resume_abus", abus, 8'h10);
    expect_run(8'h10, 6);
    wait_deliv(2);
`else
    expect_run(8'h00, 10);
    rst = 1'b0;
    wait_deliv(6);
    chk("nohalt_flag", 8'(halted), 8'd0);
`endif

    rst = 1'b1;
    step(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
